// File: rtl/two_port_sram_pkg.sv
// Shared size defaults for the two-port SRAM and anything that instantiates or exercises it.
package two_port_sram_pkg;
  localparam int SRAM_ADDR_BITS = 13;
  localparam int SRAM_DATA_BITS = 32;
endpackage

// File: rtl/two_port_sram_fwd.sv
// Write-first forwarding select: a same-address write on this edge overrides the stored word.
module two_port_sram_fwd
  import two_port_sram_pkg::*;
#(
  parameter int ADDR_BITS = SRAM_ADDR_BITS,
  parameter int DATA_BITS = SRAM_DATA_BITS
) (
  input  logic [ADDR_BITS-1:0] aa,
  input  logic [ADDR_BITS-1:0] ab,
  input  logic                 wr_valid,
  input  logic [DATA_BITS-1:0] db,
  input  logic [DATA_BITS-1:0] mem_word,
  output logic [DATA_BITS-1:0] qa_next
);
  always_comb begin
    qa_next = mem_word;
    if (wr_valid && (aa == ab)) begin
      qa_next = db;
    end
  end
endmodule

// File: rtl/two_port_sram.sv
// Single-clock SRAM: port A registered read, port B write. Same-address collisions return
// old data unless TWO_PORT_SRAM_BYPASS_EN is defined, which forwards DB (write-first).
module two_port_sram
  import two_port_sram_pkg::*;
#(
  parameter int ADDR_BITS = SRAM_ADDR_BITS,
  parameter int DATA_BITS = SRAM_DATA_BITS
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 CENA,
  input  logic [ADDR_BITS-1:0] AA,
  output logic [DATA_BITS-1:0] QA,
  input  logic                 CENB,
  input  logic                 WENB,
  input  logic [ADDR_BITS-1:0] AB,
  input  logic [DATA_BITS-1:0] DB
);
  logic [DATA_BITS-1:0] Memory [0:2**ADDR_BITS-1];

  logic                 wr_valid;
  logic [DATA_BITS-1:0] rd_word;
  logic [DATA_BITS-1:0] rd_next;
  logic [DATA_BITS-1:0] qa_d;
  logic [DATA_BITS-1:0] qa_q;

  assign wr_valid = RSTN & CENB & WENB;
  assign rd_word  = Memory[AA];

`ifdef TWO_PORT_SRAM_BYPASS_EN
  two_port_sram_fwd #(
    .ADDR_BITS(ADDR_BITS),
    .DATA_BITS(DATA_BITS)
  ) u_fwd (
    .aa      (AA),
    .ab      (AB),
    .wr_valid(wr_valid),
    .db      (DB),
    .mem_word(rd_word),
    .qa_next (rd_next)
  );
`else
  // rd_word is sampled before this edge's write lands, giving read-before-write.
  assign rd_next = rd_word;
`endif

  always_comb begin
    qa_d = qa_q;
    if (CENA) begin
      qa_d = rd_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      qa_q <= '0;
    end else begin
      qa_q <= qa_d;
    end
  end

  // Storage is deliberately outside reset so contents survive RSTN pulses.
  always_ff @(posedge CLK) begin
    if (wr_valid) begin
      Memory[AB] <= DB;
    end
  end

  assign QA = qa_q;
endmodule

// File: tb/tb_two_port_sram.sv
// Self-checking bench for two_port_sram: directed scenarios plus randomized traffic against
// a behavioural memory model. Define TWO_PORT_SRAM_BYPASS_EN to check the forwarding build.
module tb_two_port_sram;
  import two_port_sram_pkg::*;

  localparam int AW    = SRAM_ADDR_BITS;
  localparam int DW    = SRAM_DATA_BITS;
  localparam int DEPTH = 2**AW;

  logic          CLK;
  logic          RSTN;
  logic          CENA;
  logic [AW-1:0] AA;
  logic [DW-1:0] QA;
  logic          CENB;
  logic          WENB;
  logic [AW-1:0] AB;
  logic [DW-1:0] DB;

  two_port_sram #(.ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .CLK (CLK),
    .RSTN(RSTN),
    .CENA(CENA),
    .AA  (AA),
    .QA  (QA),
    .CENB(CENB),
    .WENB(WENB),
    .AB  (AB),
    .DB  (DB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic [DW-1:0] ref_qa;
  int            checks_total;
  int            checks_passed;
  bit            bypass_build;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge: apply the spec rules to the reference model, then settle past the edge.
  task automatic step();
    @(posedge CLK);
    if (RSTN) begin
      if (CENA) begin
        if (bypass_build && CENB && WENB && (AA == AB)) ref_qa = DB;
        else ref_qa = ref_mem[AA];
      end
      if (CENB && WENB) ref_mem[AB] = DB;
    end else begin
      ref_qa = '0;
    end
    #1;
  endtask

  task automatic backdoor(input int addr, input logic [DW-1:0] val);
    dut.Memory[addr] = val;
    ref_mem[addr]    = val;
  endtask

  task automatic idle();
    CENA = 1'b0; CENB = 1'b0; WENB = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pre3;
    logic [DW-1:0] pre4;
`ifdef TWO_PORT_SRAM_BYPASS_EN
    bypass_build = 1'b1;
`else
    bypass_build = 1'b0;
`endif
    checks_total = 0;
    checks_passed = 0;
    ref_qa = '0;
    RSTN = 1'b0; AA = '0; AB = '0; DB = '0;
    idle();
    for (int i = 0; i < DEPTH; i++) backdoor(i, $urandom());

    // Reset clears QA
    ref_qa = 32'hdead_beef;
    step();
    check_eq("reset_qa", QA, '0);
    RSTN = 1'b1;
    step();
    check_eq("reset_hold_qa", QA, '0);

    // Backdoor load then read 0..99
    for (int i = 0; i < 100; i++) backdoor(i, DW'(i));
    for (int i = 0; i < 100; i++) begin
      CENA = 1'b1; AA = AW'(i);
      step();
      check_eq($sformatf("bd_read[%0d]", i), QA, DW'(i));
    end
    idle();

    // Write pass then read pass
    for (int i = 0; i < 100; i++) begin
      CENB = 1'b1; WENB = 1'b1; AB = AW'(i); DB = DW'(100 - i);
      step();
    end
    idle();
    for (int i = 0; i < 100; i++) begin
      CENA = 1'b1; AA = AW'(i);
      step();
      check_eq($sformatf("wr_read[%0d]", i), QA, DW'(100 - i));
    end

    // QA holds while CENA is low
    CENA = 1'b1; AA = AW'(5);
    step();
    check_eq("hold_rd5", QA, DW'(95));
    CENA = 1'b0; AA = AW'(7);
    step();
    check_eq("hold_cena0", QA, DW'(95));
    step();
    check_eq("hold_cena0_2", QA, DW'(95));

    // Same-address collision
    backdoor(9, DW'(9));
    CENA = 1'b1; AA = AW'(9); CENB = 1'b1; WENB = 1'b1; AB = AW'(9); DB = DW'(55);
    step();
    check_eq("collide_qa", QA, bypass_build ? DW'(55) : DW'(9));
    CENB = 1'b0; WENB = 1'b0;
    step();
    check_eq("collide_reread", QA, DW'(55));

    // Reset blocks writes and reads; memory persists
    pre3 = DW'(97);
    RSTN = 1'b0; CENA = 1'b1; AA = AW'(3); CENB = 1'b1; WENB = 1'b1; AB = AW'(3); DB = DW'(77);
    step();
    check_eq("rst_qa", QA, '0);
    check_eq("rst_mem3", dut.Memory[3], pre3);
    RSTN = 1'b1; CENB = 1'b0; WENB = 1'b0;
    step();
    check_eq("rst_reread3", QA, pre3);

    // CENB=0 blocks a write even with WENB=1
    pre4 = DW'(96);
    CENA = 1'b0; CENB = 1'b0; WENB = 1'b1; AB = AW'(4); DB = DW'(88);
    step();
    check_eq("cenb0_mem4", dut.Memory[4], pre4);
    WENB = 1'b0; CENA = 1'b1; AA = AW'(4);
    step();
    check_eq("cenb0_read4", QA, pre4);

    // CENB=1, WENB=0 is a no-op
    CENA = 1'b0; CENB = 1'b1; WENB = 1'b0; AB = AW'(6); DB = DW'(123);
    step();
    check_eq("wenb0_mem6", dut.Memory[6], DW'(94));

    // Randomized traffic over a small address window to provoke collisions
    for (int n = 0; n < 2000; n++) begin
      RSTN = ($urandom_range(0, 99) >= 4);
      CENA = $urandom_range(0, 1) == 1;
      CENB = $urandom_range(0, 1) == 1;
      WENB = $urandom_range(0, 3) != 0;
      AA   = AW'($urandom_range(0, 15));
      AB   = ($urandom_range(0, 2) == 0) ? AA : AW'($urandom_range(0, 15));
      DB   = $urandom();
      step();
      check_eq($sformatf("rand_qa[%0d]", n), QA, ref_qa);
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      CENA = 1'b1; AA = AW'(i);
      step();
      check_eq($sformatf("final_read[%0d]", i), QA, ref_mem[i]);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
